hamming_tx_encoder: RTL and testbench
=====================================

HAMMING_TX_ENCODER -- requirements
Module: hamming_tx_encoder

Interface
REQ-001 SHALL have parameter MSG_W, default 8: message width; only 8 is supported.
REQ-002 SHALL have parameter CW_W, default 12: codeword width, equal to the `WIDTH macro value.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on posedge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have port in_valid, input, 1: the upstream message is valid.
REQ-006 SHALL have port in_ready, output, 1: the block accepts a message this cycle.
REQ-007 SHALL have port in_data, input, 8: the message m[7:0].
REQ-008 SHALL have port err_pos, input, 4: error-injection position, sampled with in_data; 0 means no injection.
REQ-009 SHALL have port out_valid, output, 1: out_code holds a valid codeword.
REQ-010 SHALL have port out_ready, input, 1: the downstream Hamming decoder stage consumes the word.
REQ-011 SHALL have port out_code, output, 12: codeword cw[11:0], bit i = Hamming position i+1.
REQ-012 SHALL have port tx_count, output, 8: count of codewords delivered downstream.

Function
REQ-013 SHALL accept a message when in_valid && in_ready are both high at posedge.
REQ-014 SHALL deliver a codeword when out_valid && out_ready are both high at posedge.
REQ-015 SHALL place data bits as cw[11:8]=m[7:4], cw[6:4]=m[3:1], cw[2]=m[0].
REQ-016 SHALL set cw[0]=cw2^cw4^cw6^cw8^cw10.
REQ-017 SHALL set cw[1]=cw2^cw5^cw6^cw9^cw10.
REQ-018 SHALL set cw[3]=cw4^cw5^cw6^cw11.
REQ-019 SHALL set cw[7]=cw8^cw9^cw10^cw11.
REQ-020 SHALL, for err_pos 1..12, XOR cw[err_pos-1] with 1 after parity generation; err_pos 0 or 13..15 SHALL leave the word unmodified.
REQ-021 SHALL store encoded, injected words in a 2-entry FIFO; out_code/out_valid SHALL reflect the head entry.
REQ-022 SHALL drive in_ready = (FIFO occupancy < 2), derived from registered state only, with no combinational path from out_ready.
REQ-023 SHALL, when a word is accepted into an empty FIFO at edge N, assert out_valid after edge N, giving 1-cycle latency.
REQ-024 SHALL, on simultaneous accept and deliver, leave occupancy unchanged and preserve order.
REQ-025 SHALL, when full, ignore in_valid; a delivery that cycle frees one entry, and in_ready rises the next cycle.
REQ-026 SHALL hold out_code stable while out_valid && !out_ready.
REQ-027 SHALL, when the FIFO is empty, drive out_valid=0 and hold out_code at its last value.
REQ-028 SHALL increment tx_count by 1 per delivery, wrapping 255->0.
REQ-029 SHALL have no combinational path from inputs to out_code or out_valid.

Reset
REQ-030 SHALL, when rst==0 at posedge, set FIFO occupancy to 0 and out_valid=0.
REQ-031 SHALL, when rst==0 at posedge, set out_code=12'h000, tx_count=0, and in_ready=1 from the first cycle after reset.
REQ-032 SHALL, on reset mid-operation, discard buffered words without delivering them; tx_count SHALL not count them.
REQ-033 SHALL give reset priority over simultaneous handshakes.

Structure
REQ-034 SHALL source CW_W=12, MSG_W=8, parity positions {0,1,3,7}, data-bit map and ERR_NONE=0 from a shared package, also used by the decoder stage.
REQ-035 SHALL implement parity generation as the combinational sub-module hamming_enc_core (8 in, 12 out); the FIFO, injection and counter SHALL reside in hamming_tx_encoder.

Verification
REQ-036 SHALL cover: in_data 8'h00, err_pos 0, out_ready=1 -> out_code 12'h000 one cycle later, tx_count 1.
REQ-037 SHALL cover: in_data 8'hFF -> 12'hF77; in_data 8'h01 -> 12'h007; each word decodes back through the decoder stage to the original message.
REQ-038 SHALL cover: in_data 8'hFF, err_pos 5 -> out_code 12'hF67; the decoder corrects it to decoded 8'hFF. err_pos 14 -> 12'hF77 unmodified.
REQ-039 SHALL cover: out_ready=0 while 3 messages are offered -> in_ready low after 2 accepts, out_code stable; release out_ready -> words delivered in order, third accepted after in_ready rises.
REQ-040 SHALL cover: 256 back-to-back deliveries -> tx_count wraps to 0.
REQ-041 SHALL cover: rst=0 with 2 words buffered -> out_valid 0, tx_count 0, in_ready 1 next cycle; no stale word delivered.

Source files
------------

// File: rtl/hamming_tx_encoder_pkg.sv
// Shared Hamming(12,8) definitions used by the encoder and decoder stages.
// Positions are zero-based codeword bit indices (bit i = Hamming position i+1).
package hamming_tx_encoder_pkg;

    localparam int unsigned MSG_W   = 8;
    localparam int unsigned CW_W    = 12;
    localparam int unsigned ERR_W   = 4;
    localparam int unsigned NUM_PAR = 4;

    localparam int unsigned PAR_POS [NUM_PAR] = '{0, 1, 3, 7};
    // DATA_POS[i] is the codeword bit that carries message bit m[i].
    localparam int unsigned DATA_POS [MSG_W] = '{2, 4, 5, 6, 8, 9, 10, 11};

    localparam logic [ERR_W-1:0] ERR_NONE = '0;

    typedef logic [CW_W-1:0]  codeword_t;
    typedef logic [MSG_W-1:0] msg_t;

endpackage

// File: rtl/hamming_enc_core.sv
// Combinational Hamming(12,8) parity generator.
module hamming_enc_core
    import hamming_tx_encoder_pkg::*;
(
    input  logic [7:0]  msg_i,
    output logic [11:0] code_o
);

    codeword_t code;

    always_comb begin
        code = '0;
        for (int unsigned i = 0; i < MSG_W; i++) begin
            code[4'(DATA_POS[i])] = msg_i[3'(i)];
        end
        // Parity at position p+1 covers every position whose index shares that bit.
        for (int unsigned p = 0; p < NUM_PAR; p++) begin
            for (int unsigned j = 0; j < CW_W; j++) begin
                if ((j != PAR_POS[p]) && (((j + 1) & (PAR_POS[p] + 1)) != 0)) begin
                    code[4'(PAR_POS[p])] = code[4'(PAR_POS[p])] ^ code[4'(j)];
                end
            end
        end
    end

    assign code_o = code;

endmodule

// File: rtl/hamming_tx_encoder.sv
// Hamming(12,8) transmit stage: encode, optional single-bit error injection,
// 2-entry output FIFO and a delivered-word counter.
module hamming_tx_encoder #(
    parameter int unsigned MSG_W = hamming_tx_encoder_pkg::MSG_W,
    parameter int unsigned CW_W  = hamming_tx_encoder_pkg::CW_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [MSG_W-1:0] in_data,
    input  logic [3:0]      err_pos,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [CW_W-1:0] out_code,
    output logic [7:0]      tx_count
);

    import hamming_tx_encoder_pkg::*;

    logic [CW_W-1:0] enc_code;
    logic [CW_W-1:0] inj_code;
    logic            inj_en;

    logic [CW_W-1:0] head_q, head_d;
    logic [CW_W-1:0] tail_q, tail_d;
    logic [1:0]      count_q, count_d;
    logic [7:0]      tx_count_q, tx_count_d;

    logic push;
    logic pop;

    hamming_enc_core u_enc_core (
        .msg_i  (in_data),
        .code_o (enc_code)
    );

    assign inj_en   = (err_pos != ERR_NONE) && (err_pos <= 4'(CW_W));
    assign inj_code = inj_en ? (enc_code ^ (CW_W'(1) << (err_pos - 4'd1))) : enc_code;

    assign in_ready  = (count_q < 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign out_code  = head_q;
    assign tx_count  = tx_count_q;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    // head_q is the FIFO head and keeps its last value once the FIFO drains.
    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        tx_count_d = tx_count_q;
        if (pop) begin
            tx_count_d = tx_count_q + 8'd1;
        end
        case (count_q)
            2'd0: begin
                if (push) begin
                    head_d  = inj_code;
                    count_d = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    head_d = inj_code;
                end else if (push) begin
                    tail_d  = inj_code;
                    count_d = 2'd2;
                end else if (pop) begin
                    count_d = 2'd0;
                end
            end
            2'd2: begin
                if (pop) begin
                    head_d  = tail_q;
                    count_d = 2'd1;
                end
            end
            default: begin
                count_d = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= 2'd0;
            tx_count_q <= 8'd0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            tx_count_q <= tx_count_d;
        end
    end

endmodule

// File: tb/tb_hamming_tx_encoder.sv
// Directed self-checking bench for hamming_tx_encoder with an independent syndrome decoder.
module tb_hamming_tx_encoder;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic [3:0]  err_pos;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_code;
    logic [7:0]  tx_count;

    int checks;
    int failures;
    int exp_tx;

    hamming_tx_encoder #(
        .MSG_W (8),
        .CW_W  (12)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .err_pos   (err_pos),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_code  (out_code),
        .tx_count  (tx_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Syndrome decoder standing in for the downstream decoder stage.
    function automatic logic [7:0] decode(input logic [11:0] code);
        logic [11:0] c;
        logic [3:0]  s;
        c = code;
        s = 4'd0;
        for (int i = 0; i < 12; i++) begin
            if (c[i]) s = s ^ 4'(i + 1);
        end
        if (s >= 4'd1 && s <= 4'd12) c[s - 4'd1] = ~c[s - 4'd1];
        return {c[11:8], c[6:4], c[2]};
    endfunction

    task automatic send_one(input string tag, input logic [7:0] data, input logic [3:0] err,
                            input logic [11:0] exp_code);
        in_valid  = 1'b1;
        in_data   = data;
        err_pos   = err;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check_eq({tag, "_valid"}, 32'(out_valid), 32'd1);
        check_eq({tag, "_code"}, 32'(out_code), 32'(exp_code));
        check_eq({tag, "_decoded"}, 32'(decode(out_code)), 32'(data));
        @(posedge clk);
        @(negedge clk);
        exp_tx = (exp_tx + 1) % 256;
        check_eq({tag, "_drained"}, 32'(out_valid), 32'd0);
        check_eq({tag, "_held"}, 32'(out_code), 32'(exp_code));
        check_eq({tag, "_tx"}, 32'(tx_count), 32'(exp_tx));
    endtask

    task automatic run_stream(input int n);
        int got;
        int cyc;
        got       = 0;
        cyc       = 0;
        in_valid  = 1'b1;
        in_data   = 8'hA5;
        err_pos   = 4'd0;
        out_ready = 1'b1;
        while (got < n && cyc < n + 16) begin
            @(negedge clk);
            cyc++;
            if (out_valid) begin
                got++;
                if (got == n) in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        check_eq("stream_count", 32'(got), 32'(n));
        @(negedge clk);
        exp_tx = (exp_tx + n) % 256;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        exp_tx    = 0;
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        err_pos   = 4'd0;
        out_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_code", 32'(out_code), 32'h000);
        check_eq("rst_tx_count", 32'(tx_count), 32'd0);
        rst = 1'b1;

        send_one("zero", 8'h00, 4'd0, 12'h000);
        send_one("ones", 8'hFF, 4'd0, 12'hF77);
        send_one("one", 8'h01, 4'd0, 12'h007);
        send_one("inj5", 8'hFF, 4'd5, 12'hF67);
        send_one("inj14", 8'hFF, 4'd14, 12'hF77);

        // Backpressure: two accepts fill the FIFO, third waits for space.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h12;
        @(posedge clk);
        @(negedge clk);
        check_eq("bp_ready1", 32'(in_ready), 32'd1);
        check_eq("bp_code1", 32'(out_code), 32'h198);
        in_data = 8'h34;
        @(posedge clk);
        @(negedge clk);
        check_eq("bp_full", 32'(in_ready), 32'd0);
        check_eq("bp_valid", 32'(out_valid), 32'd1);
        check_eq("bp_code2", 32'(out_code), 32'h198);
        in_data = 8'h56;
        @(posedge clk);
        @(negedge clk);
        check_eq("bp_still_full", 32'(in_ready), 32'd0);
        check_eq("bp_stable", 32'(out_code), 32'h198);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("bp_second", 32'(out_code), 32'h329);
        check_eq("bp_ready_rise", 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("bp_third", 32'(out_code), 32'h531);
        check_eq("bp_third_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        @(negedge clk);
        exp_tx = (exp_tx + 3) % 256;
        check_eq("bp_empty", 32'(out_valid), 32'd0);
        check_eq("bp_tx", 32'(tx_count), 32'(exp_tx));

        // Counter wrap from a clean reset.
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst    = 1'b1;
        exp_tx = 0;
        run_stream(255);
        check_eq("wrap_255", 32'(tx_count), 32'd255);
        run_stream(1);
        check_eq("wrap_0", 32'(tx_count), 32'd0);
        check_eq("wrap_empty", 32'(out_valid), 32'd0);

        // Reset with two words buffered and handshakes pending.
        send_one("pre_rst", 8'h01, 4'd0, 12'h007);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h12;
        @(posedge clk);
        @(negedge clk);
        in_data = 8'h34;
        @(posedge clk);
        @(negedge clk);
        check_eq("mid_full", 32'(in_ready), 32'd0);
        rst       = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        check_eq("mid_out_valid", 32'(out_valid), 32'd0);
        check_eq("mid_tx", 32'(tx_count), 32'd0);
        check_eq("mid_in_ready", 32'(in_ready), 32'd1);
        check_eq("mid_code", 32'(out_code), 32'h000);
        @(posedge clk);
        @(negedge clk);
        check_eq("mid_no_stale", 32'(out_valid), 32'd0);
        check_eq("mid_tx_hold", 32'(tx_count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
